// File: rtl/ex_flag_stage_if.sv
// Upstream instruction bus into the execute/flag stage.
interface ex_flag_stage_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic          in_is_alu;
  logic [2:0]    in_op;
  logic [DW-1:0] in_result;
  logic [2:0]    in_flags;
  logic [RW-1:0] in_dst;
  logic          in_we;
  logic          in_is_branch;
  logic [2:0]    in_cond;
  logic [DW-1:0] in_pc_inc;
  logic [8:0]    in_br_off;

  modport master (
    output in_valid, in_is_alu, in_op, in_result, in_flags, in_dst, in_we,
    output in_is_branch, in_cond, in_pc_inc, in_br_off,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_is_alu, in_op, in_result, in_flags, in_dst, in_we,
    input  in_is_branch, in_cond, in_pc_inc, in_br_off,
    output in_ready
  );
endinterface

// File: rtl/ex_flag_stage.sv
// Execute-to-memory stage: registers ALU result, owns the {Z, V, N} flag register and
// resolves conditional branches against the committed flags.
module ex_flag_stage #(
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                flush,
  ex_flag_stage_if.slave      bus,
  output logic                out_valid,
  output logic [DW-1:0]       out_result,
  output logic [RW-1:0]       out_dst,
  output logic                out_we,
  output logic [2:0]          flags_q,
  output logic                br_taken,
  output logic [DW-1:0]       br_target
);

  localparam logic [2:0] OpAdd  = 3'b000;
  localparam logic [2:0] OpSub  = 3'b001;
  localparam logic [2:0] OpNand = 3'b010;
  localparam logic [2:0] OpXor  = 3'b011;
  localparam logic [2:0] OpInc  = 3'b100;

  logic          accept;
  logic [2:0]    flags_d;
  logic          cond_true;
  logic [DW-1:0] target;
  logic          z, v, n;

  assign bus.in_ready = !stall;
  assign accept       = bus.in_valid & !stall & !flush;

  assign z = flags_q[2];
  assign v = flags_q[1];
  assign n = flags_q[0];

  // Next flag value for an ALU op; logic ops only own Z, shifts leave flags alone.
  always_comb begin
    flags_d = flags_q;
    if (bus.in_is_alu) begin
      unique case (bus.in_op)
        OpAdd, OpSub, OpInc: flags_d = bus.in_flags;
        OpNand, OpXor:       flags_d = {bus.in_flags[2], flags_q[1:0]};
        default:             flags_d = flags_q;
      endcase
    end
  end

  // Branch condition against the committed (pre-update) flags.
  always_comb begin
    cond_true = 1'b0;
    unique case (bus.in_cond)
      3'b000:  cond_true = !z;
      3'b001:  cond_true = z;
      3'b010:  cond_true = !z & !n;
      3'b011:  cond_true = n;
      3'b100:  cond_true = z | (!z & !n);
      3'b101:  cond_true = n | z;
      3'b110:  cond_true = v;
      default: cond_true = 1'b1;
    endcase
  end

  // Target wraps modulo 2^DW.
  assign target = bus.in_pc_inc + {{(DW-9){bus.in_br_off[8]}}, bus.in_br_off};

  // Pipeline, flag and branch registers; flush beats stall beats accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_dst    <= '0;
      out_we     <= 1'b0;
      flags_q    <= 3'b000;
      br_taken   <= 1'b0;
      br_target  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_we    <= 1'b0;
      br_taken  <= 1'b0;
    end else if (!stall) begin
      if (accept) begin
        out_valid  <= 1'b1;
        out_result <= bus.in_result;
        out_dst    <= bus.in_dst;
        out_we     <= bus.in_we;
        flags_q    <= flags_d;
        br_taken   <= bus.in_is_branch & cond_true;
        if (bus.in_is_branch) begin
          br_target <= target;
        end
      end else begin
        out_valid <= 1'b0;
        out_we    <= 1'b0;
        br_taken  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_flag_stage.sv
// Randomized and directed bench for ex_flag_stage with a behavioural model.
module tb_ex_flag_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic        out_valid, out_we, br_taken;
  logic [15:0] out_result, br_target;
  logic [3:0]  out_dst;
  logic [2:0]  flags_q;

  int total = 0;
  int bad   = 0;

  // Model state
  logic        m_valid, m_we, m_taken;
  logic [15:0] m_result, m_target;
  logic [3:0]  m_dst;
  logic [2:0]  m_flags;

  ex_flag_stage_if #(.DW(16), .RW(4)) bus ();

  ex_flag_stage #(.DW(16), .RW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .flush      (flush),
    .bus        (bus),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_dst    (out_dst),
    .out_we     (out_we),
    .flags_q    (flags_q),
    .br_taken   (br_taken),
    .br_target  (br_target)
  );

  always #5 clk = ~clk;

  logic [41:0] act;
  assign act = {out_valid, out_result, out_dst, out_we, flags_q, br_taken, br_target};

  function automatic logic [41:0] expv();
    return {m_valid, m_result, m_dst, m_we, m_flags, m_taken, m_target};
  endfunction

  function automatic bit cond_holds(input logic [2:0] c, input logic [2:0] f);
    bit zf, vf, nf;
    zf = f[2]; vf = f[1]; nf = f[0];
    case (c)
      3'd0:    return !zf;
      3'd1:    return zf;
      3'd2:    return !zf && !nf;
      3'd3:    return nf;
      3'd4:    return zf || (!zf && !nf);
      3'd5:    return nf || zf;
      3'd6:    return vf;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_we = 0; m_taken = 0;
    m_result = '0; m_target = '0; m_dst = '0; m_flags = '0;
  endtask

  // Applies the stage rules to whatever the bench is presenting at this edge.
  task automatic model_step();
    int t;
    logic [2:0] old_flags;
    if (flush) begin
      m_valid = 0; m_we = 0; m_taken = 0;
    end else if (stall) begin
      // everything holds
    end else if (bus.in_valid) begin
      old_flags = m_flags;
      m_valid  = 1;
      m_result = bus.in_result;
      m_dst    = bus.in_dst;
      m_we     = bus.in_we;
      if (bus.in_is_alu) begin
        if (bus.in_op inside {3'd0, 3'd1, 3'd4}) m_flags = bus.in_flags;
        else if (bus.in_op inside {3'd2, 3'd3}) m_flags[2] = bus.in_flags[2];
      end
      m_taken = bus.in_is_branch && cond_holds(bus.in_cond, old_flags);
      if (bus.in_is_branch) begin
        t = int'(bus.in_pc_inc) + int'($signed(bus.in_br_off));
        m_target = t[15:0];
      end
    end else begin
      m_valid = 0; m_we = 0; m_taken = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_in();
    bus.in_valid = 0; bus.in_is_alu = 0; bus.in_op = 0; bus.in_result = 0;
    bus.in_flags = 0; bus.in_dst = 0; bus.in_we = 0; bus.in_is_branch = 0;
    bus.in_cond = 0; bus.in_pc_inc = 0; bus.in_br_off = 0;
  endtask

  task automatic alu(input logic [2:0] op, input logic [2:0] fl);
    clear_in();
    bus.in_valid = 1; bus.in_is_alu = 1; bus.in_op = op; bus.in_flags = fl;
    bus.in_result = 16'($urandom); bus.in_dst = 4'($urandom); bus.in_we = 1;
  endtask

  task automatic branch(input logic [2:0] c, input logic [15:0] pc, input logic [8:0] off);
    clear_in();
    bus.in_valid = 1; bus.in_is_branch = 1; bus.in_cond = c;
    bus.in_pc_inc = pc; bus.in_br_off = off;
  endtask

  task automatic test_reset();
    rst_n = 0; stall = 0; flush = 0; clear_in(); model_reset();
    #2;
    total++;
    if (act !== 42'd0) begin
      bad++; $display("FAIL reset_init: got %h want 0", act);
    end
    #5 rst_n = 1;
    // Mid-stream reset with valid data and all flags set.
    alu(3'd0, 3'b111);
    cycle();
    total++;
    if (out_valid !== 1'b1 || flags_q !== 3'b111 || act !== expv()) begin
      bad++; $display("FAIL reset_preload: got %h want %h", act, expv());
    end
    #2 rst_n = 0;
    #1;
    total++;
    if (act !== 42'd0) begin
      bad++; $display("FAIL reset_async: got %h want 0", act);
    end
    model_reset();
    clear_in();
    #3 rst_n = 1;
  endtask

  task automatic test_flags();
    alu(3'd0, 3'b101); cycle();
    total++;
    if (flags_q !== 3'b101 || act !== expv()) begin
      bad++; $display("FAIL flags_add: got %b want 101", flags_q);
    end
    alu(3'd3, 3'b000); cycle();
    total++;
    if (flags_q !== 3'b001 || act !== expv()) begin
      bad++; $display("FAIL flags_xor: got %b want 001", flags_q);
    end
    alu(3'd7, 3'b111); cycle();
    total++;
    if (flags_q !== 3'b001 || act !== expv()) begin
      bad++; $display("FAIL flags_sll: got %b want 001", flags_q);
    end
  endtask

  task automatic test_back_to_back();
    alu(3'd1, 3'b100); cycle();
    branch(3'd1, 16'h0010, 9'h1FE); cycle();
    total++;
    if (br_taken !== 1'b1 || br_target !== 16'h000E || act !== expv()) begin
      bad++; $display("FAIL b2b_eq: taken=%b target=%h want 1 000e", br_taken, br_target);
    end
    alu(3'd1, 3'b100); cycle();
    total++;
    if (br_taken !== 1'b0 || act !== expv()) begin
      bad++; $display("FAIL b2b_alu_clears: taken=%b want 0", br_taken);
    end
    branch(3'd0, 16'h0010, 9'h1FE); cycle();
    total++;
    if (br_taken !== 1'b0 || br_target !== 16'h000E || act !== expv()) begin
      bad++; $display("FAIL b2b_ne: taken=%b target=%h want 0 000e", br_taken, br_target);
    end
  endtask

  task automatic test_wrap();
    branch(3'd7, 16'hFFFF, 9'h002); cycle();
    total++;
    if (br_taken !== 1'b1 || br_target !== 16'h0001 || act !== expv()) begin
      bad++; $display("FAIL wrap: taken=%b target=%h want 1 0001", br_taken, br_target);
    end
  endtask

  task automatic test_stall_flush();
    alu(3'd0, 3'b001); cycle();
    stall = 1; alu(3'd1, 3'b110);
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL stall_ready: got %b want 0", bus.in_ready);
    end
    cycle();
    total++;
    if (out_valid !== 1'b1 || flags_q !== 3'b001 || act !== expv()) begin
      bad++; $display("FAIL stall_hold: got %h want %h", act, expv());
    end
    stall = 0; flush = 1; alu(3'd0, 3'b010); cycle();
    total++;
    if (out_valid !== 1'b0 || out_we !== 1'b0 || flags_q !== 3'b001 || act !== expv()) begin
      bad++; $display("FAIL flush: got %h want %h", act, expv());
    end
    flush = 0; alu(3'd0, 3'b100); cycle();
    stall = 1; flush = 1; alu(3'd0, 3'b010); cycle();
    total++;
    if (out_valid !== 1'b0 || flags_q !== 3'b100 || act !== expv()) begin
      bad++; $display("FAIL stall_flush: got %h want %h", act, expv());
    end
    stall = 0; flush = 0;
  endtask

  task automatic test_stall_pulse();
    branch(3'd7, 16'h1234, 9'h010); cycle();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (br_taken !== 1'b1 || act !== expv()) begin
        bad++; $display("FAIL pulse_stretch%0d: taken=%b want 1", i, br_taken);
      end
      if (i < 2) cycle();
    end
    stall = 0; clear_in(); cycle();
    total++;
    if (br_taken !== 1'b0 || out_valid !== 1'b0 || act !== expv()) begin
      bad++; $display("FAIL pulse_drop: taken=%b want 0", br_taken);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      bus.in_valid     = ($urandom_range(0, 3) != 0);
      bus.in_is_alu    = 1'($urandom);
      bus.in_op        = 3'($urandom);
      bus.in_result    = 16'($urandom);
      bus.in_flags     = 3'($urandom);
      bus.in_dst       = 4'($urandom);
      bus.in_we        = 1'($urandom);
      bus.in_is_branch = 1'($urandom);
      bus.in_cond      = 3'($urandom);
      bus.in_pc_inc    = ($urandom_range(0, 7) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15))
                                                      : 16'($urandom);
      bus.in_br_off    = 9'($urandom);
      #1;
      total++;
      if (bus.in_ready !== !stall) begin
        bad++; $display("FAIL rand_ready%0d: got %b want %b", i, bus.in_ready, !stall);
      end
      cycle();
      total++;
      if (act !== expv()) begin
        bad++; $display("FAIL rand_state%0d: got %h want %h", i, act, expv());
      end
    end
    stall = 0; flush = 0; clear_in();
  endtask

  initial begin
    test_reset();
    test_flags();
    test_back_to_back();
    test_wrap();
    test_stall_flush();
    test_stall_pulse();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_flag_stage.md
# ex_flag_stage

Execute-to-memory pipeline stage that sits directly downstream of the 16-bit ALU. It registers the ALU result and destination, and owns the architectural flag register {Z, V, N}, updating it per opcode class. It also resolves conditional branches against the committed flags and produces the branch-taken pulse and target for the fetch stage. Stall and flush come from the hazard unit.

## Interface
Parameters:
- DW, 16, datapath width.
- RW, 4, register-index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold all state; incoming instruction not accepted.
- flush  in  1  discard the incoming instruction and clear out_valid.
- in_valid  in  1  upstream instruction present.
- in_ready  out  1  combinational, equal to !stall.
- in_is_alu  in  1  instruction is an ALU op and may update the flags.
- in_op  in  3  ALU opcode: ADD=000, SUB=001, NAND=010, XOR=011, INC=100, SRA=101, SRL=110, SLL=111.
- in_result  in  DW  ALU result.
- in_flags  in  3  ALU flags {Z, V, N}.
- in_dst  in  RW  destination register.
- in_we  in  1  register write enable.
- in_is_branch  in  1  conditional branch.
- in_cond  in  3  branch condition code.
- in_pc_inc  in  DW  PC+1 of the branch.
- in_br_off  in  9  signed word offset.
- out_valid  out  1  registered; stage holds a valid instruction.
- out_result  out  DW  registered result.
- out_dst  out  RW  registered destination.
- out_we  out  1  registered write enable, forced to 0 when out_valid=0.
- flags_q  out  3  committed {Z, V, N}.
- br_taken  out  1  registered one-cycle pulse.
- br_target  out  DW  registered branch target.

## Operation
- **Accept:** accept = in_valid & !stall & !flush. Only accepted instructions change out_*, flags_q or br_*.
- **Pipeline register:** on accept, load out_result, out_dst and out_we; set out_valid=1.
  - Cycle with no accept and no stall: out_valid=0 and out_we=0 (a bubble).
- **Flag update on accept with in_is_alu=1:**
  - ADD, SUB, INC: flags_q ← in_flags.
  - NAND, XOR: Z ← in_flags[2]; V and N retained.
  - SRA, SRL, SLL: flags_q unchanged.
  - Non-ALU instructions never touch the flags.
- **Branch evaluation on accept with in_is_branch=1:** evaluated against the current flags_q, which reflects all earlier accepted instructions.
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GE: Z | (!Z & !N)
  - 101 LE: N | Z
  - 110 OV: V
  - 111 always
- **Branch target:** br_target = in_pc_inc + sign_extend(in_br_off), computed at DW bits with wrap-around modulo 2^DW. br_target is loaded whenever a branch is accepted, taken or not.
- **Branch pulse:** br_taken=1 for exactly the cycle after acceptance when the condition holds; 0 in every other cycle.
- **Flag-updating branch:** if in_is_branch and in_is_alu are both set, the branch evaluates the old flags_q and the flag update then applies.
- **Priority:** rst_n low > flush > stall > accept.
- **Flush:** out_valid, out_we and br_taken go to 0 on the next edge; flags_q is not updated by the flushed instruction.
- **Stall:** all registers hold, including br_taken. A taken pulse therefore stretches while stall is high.

## Timing
- Reset (asynchronous assert, synchronous release): out_valid=0, out_result=0, out_dst=0, out_we=0, flags_q=3'b000, br_taken=0, br_target=0.
- Reset asserted mid-operation clears all state immediately, with no clock required.
- Latency is one cycle from an accepting edge to out_* and flags_q. br_taken and br_target become valid in the cycle after the branch is accepted.
- in_ready is combinational from stall; there is no other combinational input-to-output path.
- Throughput is one instruction per cycle when stall=0.

## Test plan
- Reset: drive rst_n=0 mid-stream with out_valid=1 and flags_q=3'b111 → all outputs 0 before the next clock edge.
- Flag update: ADD with in_flags=3'b101, then XOR with in_flags=3'b000, then SLL with in_flags=3'b111 → flags_q reads 101, then 001, then 001.
- Back-to-back branch: SUB with in_flags=3'b100, then the next cycle a branch with cond=001 (EQ), in_pc_inc=16'h0010, in_br_off=9'h1FE → br_taken=1 and br_target=16'h000E one cycle later. Repeat with cond=000 (NE) → br_taken=0.
- Target wrap: in_pc_inc=16'hFFFF, in_br_off=9'h002, cond=111 → br_target=16'h0001, br_taken=1.
- Stall and flush:
  - stall=1 while in_valid=1 → outputs held and in_ready=0.
  - flush=1 with a valid ADD (in_flags=3'b010) → out_valid=0 next cycle and flags_q unchanged.
  - stall=1 and flush=1 together → flush behaviour.
- Stalled pulse: taken branch accepted, then stall=1 for 2 cycles → br_taken stays 1 for 3 cycles, then drops once the stage advances with no branch accepted.
